parking_event_decoder: RTL
==========================

// Module: parking_event_decoder
// PURPOSE
//  Consumes two debounced beam-sensor levels (sensor_a street side, sensor_b lot side) on the
//  slow system clock and decodes vehicle direction from their blocking order: A->AB->B->clear is
//  an entry, B->AB->A->clear is an exit. Keeps the saturating occupancy count with full/empty
//  flags for the display and barrier logic. Sits directly downstream of the per-sensor debouncers.
// PARAMETERS
//  CAPACIDAD  16    lot capacity; occupancy saturates here (1..2**CNT_W-1)
//  CNT_W      5     width of ocupacion
//  TIMEOUT    2000  max cycles in any non-idle state (2 s at 1 kHz); >=2
// PORTS
//  clk        in   1      system clock (slow, e.g. 1 kHz), same domain as the debouncers
//  rst_n      in   1      asynchronous active-low reset
//  sensor_a   in   1      debounced street-side beam, 1 = blocked, synchronous to clk
//  sensor_b   in   1      debounced lot-side beam, 1 = blocked, synchronous to clk
//  entrada    out  1      one-cycle pulse: valid entry counted
//  salida     out  1      one-cycle pulse: valid exit counted
//  error      out  1      one-cycle pulse: aborted/illegal sequence, timeout, or over/underflow
//  ocupacion  out  CNT_W  current occupancy, 0..CAPACIDAD
//  lleno      out  1      ocupacion == CAPACIDAD
//  vacio      out  1      ocupacion == 0
// BEHAVIOUR
//  - Reset (async assert, sync-released by clk): state IDLE, ocupacion=0, vacio=1, lleno=0,
//    entrada=salida=error=0, timeout counter=0. Mid-sequence reset discards the sequence, no pulse.
//  - Sensors sampled directly each posedge (already synchronous). All outputs registered;
//    lleno/vacio decoded from the ocupacion register (no extra cycle).
//  - States (AB = both blocked, -- = both clear):
//    IDLE:   A only->IN_A; B only->OUT_B; AB->error pulse, WAIT_CLR; -- stay.
//    IN_A:   AB->IN_AB; --->IDLE (no event); B only->error, WAIT_CLR; A only stay.
//    IN_AB:  B only->IN_B; A only->IN_A (backing out); --->error, IDLE; AB stay.
//    IN_B:   --->IDLE + entry event; AB->IN_AB; A only->error, WAIT_CLR; B only stay.
//    OUT_B/OUT_AB/OUT_A: mirror of IN_* with A and B swapped; completion = exit event.
//    WAIT_CLR: --->IDLE; otherwise stay; no events, no timeout.
//  - Event latency: pulse high in the cycle after the edge that samples -- in IN_B/OUT_A;
//    ocupacion changes on that same edge. Pulses are exactly one cycle.
//  - Entry with lleno=1: entrada suppressed, ocupacion held, error pulsed instead.
//    Exit with vacio=1: salida suppressed, ocupacion held, error pulsed instead.
//  - Timeout: counter clears on every state change and in IDLE/WAIT_CLR; reaching TIMEOUT
//    consecutive cycles in one other state -> error pulse, WAIT_CLR.
//  - entrada and salida are never high in the same cycle; error never high with either.
// CONFIGURATION
//  OCUPACION_CARGA_EN defined: adds ports carga (in,1) and valor_carga (in,CNT_W). carga=1 loads
//   ocupacion <= min(valor_carga, CAPACIDAD) next edge; load wins over a same-cycle count
//   (event pulse still emitted, count discarded). FSM state unaffected.
//  Not defined: ports absent; ocupacion changes only through decoded events and reset.
// TESTING
//  1. Reset, A,AB,B,-- each held 3 cycles -> one entrada pulse, ocupacion 0->1, vacio 1->0.
//  2. From ocupacion=1: B,AB,A,-- -> one salida pulse, ocupacion 0, vacio=1; repeat -> error
//     pulse only, ocupacion stays 0.
//  3. A,AB,A,-- (car backs out) -> no entrada/salida/error, ocupacion unchanged, state IDLE.
//  4. 16 entries -> lleno=1 at ocupacion=16; 17th entry -> error pulse, ocupacion stays 16.
//  5. A held 2000 cycles -> error pulse at cycle 2000; release A -> IDLE; then AB from IDLE ->
//     error, WAIT_CLR until --.
//  6. rst_n low mid IN_AB -> all outputs reset immediately (async); with OCUPACION_CARGA_EN,
//     carga=1 valor_carga=20 -> ocupacion=16, lleno=1.

Source files
------------

// File: rtl/parking_event_decoder.sv
// rtl/parking_event_decoder.sv - beam-order direction decoder with saturating lot occupancy count.
// Optional OCUPACION_CARGA_EN adds a direct occupancy load port (carga/valor_carga).
module parking_event_decoder #(
    parameter int CAPACIDAD = 16,
    parameter int CNT_W     = 5,
    parameter int TIMEOUT   = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_a,
    input  logic             sensor_b,
`ifdef OCUPACION_CARGA_EN
    input  logic             carga,
    input  logic [CNT_W-1:0] valor_carga,
`endif
    output logic             entrada,
    output logic             salida,
    output logic             error,
    output logic [CNT_W-1:0] ocupacion,
    output logic             lleno,
    output logic             vacio
);

    localparam int               TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACIDAD);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_A    = 2'b10;
    localparam logic [1:0] S_AB   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_AB,
        OUT_A,
        WAIT_CLR
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [1:0]       sens;
    logic             active;
    logic             stay;

    // Sensor pattern that keeps each sequence state where it is.
    function automatic logic [1:0] hold_code(input state_t st);
        case (st)
            IN_A, OUT_A:   return S_A;
            IN_AB, OUT_AB: return S_AB;
            IN_B, OUT_B:   return S_B;
            default:       return S_NONE;
        endcase
    endfunction

    assign sens   = {sensor_a, sensor_b};
    assign active = (state != IDLE) && (state != WAIT_CLR);
    assign stay   = active && (sens == hold_code(state));
    assign lleno  = (ocupacion == CAP);
    assign vacio  = (ocupacion == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            ocupacion <= '0;
            entrada   <= 1'b0;
            salida    <= 1'b0;
            error     <= 1'b0;
        end else begin
            entrada <= 1'b0;
            salida  <= 1'b0;
            error   <= 1'b0;

            if (stay) begin
                // A vehicle parked in a beam (or a stuck sensor) must not wedge the decoder.
                if (tmr == TMR_LAST) begin
                    error <= 1'b1;
                    state <= WAIT_CLR;
                    tmr   <= '0;
                end else begin
                    tmr <= tmr + 1'b1;
                end
            end else begin
                tmr <= '0;
                case (state)
                    IDLE: begin
                        case (sens)
                            S_A:  state <= IN_A;
                            S_B:  state <= OUT_B;
                            S_AB: begin
                                error <= 1'b1;
                                state <= WAIT_CLR;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                    IN_A: begin
                        case (sens)
                            S_AB:   state <= IN_AB;
                            S_NONE: state <= IDLE;
                            default: begin
                                error <= 1'b1;
                                state <= WAIT_CLR;
                            end
                        endcase
                    end
                    IN_AB: begin
                        case (sens)
                            S_B: state <= IN_B;
                            S_A: state <= IN_A;
                            default: begin
                                error <= 1'b1;
                                state <= IDLE;
                            end
                        endcase
                    end
                    IN_B: begin
                        case (sens)
                            S_NONE: begin
                                state <= IDLE;
                                if (ocupacion == CAP) begin
                                    error <= 1'b1;
                                end else begin
                                    entrada   <= 1'b1;
                                    ocupacion <= ocupacion + ONE;
                                end
                            end
                            S_AB: state <= IN_AB;
                            default: begin
                                error <= 1'b1;
                                state <= WAIT_CLR;
                            end
                        endcase
                    end
                    OUT_B: begin
                        case (sens)
                            S_AB:   state <= OUT_AB;
                            S_NONE: state <= IDLE;
                            default: begin
                                error <= 1'b1;
                                state <= WAIT_CLR;
                            end
                        endcase
                    end
                    OUT_AB: begin
                        case (sens)
                            S_A: state <= OUT_A;
                            S_B: state <= OUT_B;
                            default: begin
                                error <= 1'b1;
                                state <= IDLE;
                            end
                        endcase
                    end
                    OUT_A: begin
                        case (sens)
                            S_NONE: begin
                                state <= IDLE;
                                if (ocupacion == '0) begin
                                    error <= 1'b1;
                                end else begin
                                    salida    <= 1'b1;
                                    ocupacion <= ocupacion - ONE;
                                end
                            end
                            S_AB: state <= OUT_AB;
                            default: begin
                                error <= 1'b1;
                                state <= WAIT_CLR;
                            end
                        endcase
                    end
                    WAIT_CLR: begin
                        if (sens == S_NONE) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

`ifdef OCUPACION_CARGA_EN
            // Placed last so a load overrides any count decoded on the same edge.
            if (carga) begin
                ocupacion <= (valor_carga > CAP) ? CAP : valor_carga;
            end
`endif
        end
    end

endmodule
